// File: rtl/button_mode_ctrl.sv
// Front-panel button sequencer: classifies MODE/UP/DOWN presses,
// runs the display-mode FSM and the adjustable alarm threshold.
module button_mode_ctrl #(
  parameter int CLKFREQ    = 1000,
  parameter int LONG_MS    = 1000,
  parameter int REPEAT_MS  = 200,
  parameter int TIMEOUT_MS = 5000,
  parameter int THR_W      = 8,
  parameter int THR_MIN    = 40,
  parameter int THR_MAX    = 180,
  parameter int THR_INIT   = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_mode,
  input  logic             btn_up,
  input  logic             btn_down,
  output logic [1:0]       mode,
  output logic [THR_W-1:0] threshold,
  output logic             edit_active,
  output logic             mode_pulse,
  output logic             thr_pulse
);

  localparam int LONG_RAW = LONG_MS * CLKFREQ / 1000;
  localparam int REP_RAW  = REPEAT_MS * CLKFREQ / 1000;
  localparam int TMO_RAW  = TIMEOUT_MS * CLKFREQ / 1000;
  localparam int LONG_CYC = (LONG_RAW < 1) ? 1 : LONG_RAW;
  localparam int REP_CYC  = (REP_RAW < 1) ? 1 : REP_RAW;
  localparam int TMO_CYC  = (TMO_RAW < 1) ? 1 : TMO_RAW;
  localparam int LW = $clog2(LONG_CYC) + 1;
  localparam int RW = $clog2(REP_CYC) + 1;
  localparam int TW = $clog2(TMO_CYC) + 1;

  localparam logic [LW-1:0] LONG_V  = LW'(LONG_CYC);
  localparam logic [LW-1:0] LONG_M1 = LW'(LONG_CYC - 1);
  localparam logic [RW-1:0] REP_M1  = RW'(REP_CYC - 1);
  localparam logic [TW-1:0] TMO_V   = TW'(TMO_CYC);
  localparam logic [TW-1:0] TMO_M1  = TW'(TMO_CYC - 1);
  localparam logic [THR_W-1:0] TMIN  = THR_W'(THR_MIN);
  localparam logic [THR_W-1:0] TMAX  = THR_W'(THR_MAX);
  localparam logic [THR_W-1:0] TINIT = THR_W'(THR_INIT);

  typedef enum logic [1:0] {
    VIEW_HR   = 2'd0,
    VIEW_TEMP = 2'd1,
    VIEW_SPO2 = 2'd2,
    EDIT      = 2'd3
  } mode_e;

  logic [2:0]       w_lvl, w_press, w_held, w_rel, w_clr, w_long;
  logic [2:1]       w_rpt;
  logic             w_both, w_act, w_tmo;
  logic             w_m_short, w_up, w_dn;
  logic [2:0]       r_prev, r_arm;
  logic [LW-1:0]    r_cnt [3];
  logic [RW-1:0]    r_rep [1:2];
  logic [TW-1:0]    r_idle;
  mode_e            r_mode, w_mode_nxt;
  logic [THR_W-1:0] r_thr, w_thr_nxt;
  logic             r_edit, r_mpulse, r_tpulse;

  assign w_lvl   = {btn_down, btn_up, btn_mode};
  assign w_press = w_lvl & ~r_prev;
  assign w_held  = w_lvl & r_prev;
  assign w_rel   = ~w_lvl & r_prev;
  assign w_both  = btn_up & btn_down;
  assign w_act   = |w_lvl;
  // UP+DOWN together restart both hold timers from zero
  assign w_clr   = w_press | {w_both, w_both, 1'b0};

  always_comb begin
    w_long = '0;
    w_rpt  = '0;
    for (int i = 0; i < 3; i++) begin
      w_long[i] = w_held[i] & r_arm[i] & ~w_clr[i]
                & (r_cnt[i] == LONG_M1);
    end
    for (int i = 1; i < 3; i++) begin
      w_rpt[i] = w_held[i] & r_arm[i] & ~w_both
               & (r_cnt[i] == LONG_V) & (r_rep[i] == REP_M1);
    end
  end

  assign w_m_short = w_rel[0] & r_arm[0] & (r_cnt[0] < LONG_V);
  assign w_up  = (w_press[1] & ~btn_down) | w_long[1] | w_rpt[1];
  assign w_dn  = (w_press[2] & ~btn_up) | w_long[2] | w_rpt[2];
  assign w_tmo = ~w_act & (r_idle >= TMO_M1);

  // arm bit blocks any event from a button held through reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 3'b111;
      r_arm  <= '0;
      for (int i = 0; i < 3; i++) r_cnt[i] <= LONG_V;
      for (int i = 1; i < 3; i++) r_rep[i] <= '0;
    end else begin
      r_prev <= w_lvl;
      r_arm  <= (r_arm & ~w_rel) | w_press;
      for (int i = 0; i < 3; i++) begin
        if (w_clr[i])
          r_cnt[i] <= '0;
        else if (w_held[i] && r_cnt[i] != LONG_V)
          r_cnt[i] <= r_cnt[i] + 1'b1;
      end
      for (int i = 1; i < 3; i++) begin
        if (w_clr[i] || !w_held[i] || r_cnt[i] != LONG_V
            || r_rep[i] == REP_M1)
          r_rep[i] <= '0;
        else
          r_rep[i] <= r_rep[i] + 1'b1;
      end
    end
  end

  always_comb begin
    w_mode_nxt = r_mode;
    w_thr_nxt  = r_thr;
    case (r_mode)
      EDIT: begin
        if (w_m_short || w_long[0] || w_tmo)
          w_mode_nxt = VIEW_HR;
        else if (w_up && r_thr < TMAX)
          w_thr_nxt = r_thr + 1'b1;
        else if (w_dn && r_thr > TMIN)
          w_thr_nxt = r_thr - 1'b1;
      end
      default: begin
        if (w_long[0])
          w_mode_nxt = EDIT;
        else if (w_m_short)
          w_mode_nxt = (r_mode == VIEW_SPO2) ? VIEW_HR
                     : mode_e'(r_mode + 2'd1);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode   <= VIEW_HR;
      r_thr    <= TINIT;
      r_edit   <= 1'b0;
      r_mpulse <= 1'b0;
      r_tpulse <= 1'b0;
      r_idle   <= '0;
    end else begin
      r_mode   <= w_mode_nxt;
      r_thr    <= w_thr_nxt;
      r_edit   <= (w_mode_nxt == EDIT);
      r_mpulse <= (w_mode_nxt != r_mode);
      r_tpulse <= (w_thr_nxt != r_thr);
      if (w_act || (r_mode != EDIT && w_mode_nxt == EDIT))
        r_idle <= '0;
      else if (r_idle != TMO_V)
        r_idle <= r_idle + 1'b1;
    end
  end

  assign mode        = r_mode;
  assign threshold   = r_thr;
  assign edit_active = r_edit;
  assign mode_pulse  = r_mpulse;
  assign thr_pulse   = r_tpulse;

endmodule

// File: tb/tb_button_mode_ctrl.sv
// Directed bench for button_mode_ctrl with short test timings
// (LONG=10, REPEAT=4, TIMEOUT=50 cycles).
module tb_button_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_mode, btn_up, btn_down;
  logic [1:0] mode;
  logic [7:0] threshold;
  logic       edit_active, mode_pulse, thr_pulse;

  int n_vec = 0;
  int n_bad = 0;
  int n_mp  = 0;
  int n_tp  = 0;
  int mp0, tp0;

  always #5 clk = ~clk;

  button_mode_ctrl #(
    .CLKFREQ(1000), .LONG_MS(10), .REPEAT_MS(4), .TIMEOUT_MS(50),
    .THR_W(8), .THR_MIN(40), .THR_MAX(180), .THR_INIT(100)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .mode(mode), .threshold(threshold),
    .edit_active(edit_active),
    .mode_pulse(mode_pulse), .thr_pulse(thr_pulse)
  );

  always @(negedge clk) begin
    if (mode_pulse) n_mp++;
    if (thr_pulse) n_tp++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mpress(input int n);
    btn_mode = 1'b1;
    tick(n);
    btn_mode = 1'b0;
    tick(1);
  endtask

  initial begin
    rst_n = 1'b0;
    btn_mode = 1'b0;
    btn_up = 1'b0;
    btn_down = 1'b0;
    tick(2);
    chk("rst_mode", mode, 0);
    chk("rst_thr", threshold, 100);
    chk("rst_edit", edit_active, 0);
    chk("rst_mp", mode_pulse, 0);
    chk("rst_tp", thr_pulse, 0);
    rst_n = 1'b1;
    tick(1);

    mp0 = n_mp;
    mpress(3);
    chk("view1", mode, 1);
    chk("mpulse1", mode_pulse, 1);
    tick(1);
    mpress(3);
    chk("view2", mode, 2);
    tick(1);
    mpress(3);
    chk("wrap", mode, 0);
    tick(1);
    chk("mp_count", n_mp - mp0, 3);
    chk("thr_view", threshold, 100);

    btn_mode = 1'b1;
    tick(10);
    chk("pre_long", mode, 0);
    tick(1);
    chk("long_edit", mode, 3);
    chk("edit_act", edit_active, 1);
    chk("long_mp", mode_pulse, 1);
    tick(4);
    btn_mode = 1'b0;
    tick(2);
    chk("long_rel", mode, 3);
    mpress(3);
    chk("edit_exit", mode, 0);
    chk("edit_clr", edit_active, 0);
    tick(1);

    btn_up = 1'b1;
    tick(2);
    btn_up = 1'b0;
    tick(1);
    chk("up_view", threshold, 100);

    mpress(11);
    chk("edit2", mode, 3);
    tp0 = n_tp;
    btn_up = 1'b1;
    tick(1);
    chk("up_press", threshold, 101);
    chk("tpulse", thr_pulse, 1);
    tick(9);
    chk("up_pre_long", threshold, 101);
    tick(1);
    chk("up_long", threshold, 102);
    tick(4);
    chk("up_rpt1", threshold, 103);
    tick(4);
    chk("up_rpt2", threshold, 104);
    tick(1);
    btn_up = 1'b0;
    tick(1);
    chk("up_steps", n_tp - tp0, 4);

    btn_up = 1'b1;
    tick(400);
    btn_up = 1'b0;
    tick(1);
    chk("sat_max", threshold, 180);
    btn_down = 1'b1;
    tick(2);
    btn_down = 1'b0;
    tick(1);
    chk("dn_179", threshold, 179);
    tp0 = n_tp;
    btn_up = 1'b1;
    tick(30);
    btn_up = 1'b0;
    tick(1);
    chk("max_hold", threshold, 180);
    chk("max_pulses", n_tp - tp0, 1);

    btn_down = 1'b1;
    tick(700);
    btn_down = 1'b0;
    tick(1);
    chk("sat_min", threshold, 40);
    btn_up = 1'b1;
    tick(2);
    btn_up = 1'b0;
    tick(1);
    chk("up_41", threshold, 41);
    tp0 = n_tp;
    btn_down = 1'b1;
    tick(30);
    btn_down = 1'b0;
    tick(1);
    chk("min_hold", threshold, 40);
    chk("min_pulses", n_tp - tp0, 1);
    chk("still_edit", mode, 3);

    tp0 = n_tp;
    btn_up = 1'b1;
    btn_down = 1'b1;
    tick(20);
    chk("both_thr", threshold, 40);
    btn_up = 1'b0;
    btn_down = 1'b0;
    tick(49);
    chk("pre_tmo", mode, 3);
    chk("both_pulses", n_tp - tp0, 0);
    tick(1);
    chk("tmo", mode, 0);
    chk("tmo_mp", mode_pulse, 1);
    chk("tmo_thr", threshold, 40);

    rst_n = 1'b0;
    btn_mode = 1'b1;
    tick(2);
    chk("rst2_thr", threshold, 100);
    rst_n = 1'b1;
    tick(20);
    chk("hold_rst", mode, 0);
    btn_mode = 1'b0;
    tick(2);
    chk("hold_rel", mode, 0);
    mpress(3);
    chk("fresh", mode, 1);
    tick(1);

    mpress(11);
    chk("edit3", mode, 3);
    btn_up = 1'b1;
    tick(1);
    btn_up = 1'b0;
    chk("pre_rst_thr", threshold, 101);
    tick(1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_mode", mode, 0);
    chk("async_thr", threshold, 100);
    chk("async_edit", edit_active, 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    chk("post_rst", mode, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
